// File: rtl/seq_pkg.sv
// Shared opcodes, state encoding and strobe bundle for the hardwired datapath sequencer.
package seq_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef struct packed {
    logic       PCout;
    logic       PCin;
    logic       IncPC;
    logic       MARin;
    logic       MDRin;
    logic       MDRout;
    logic       IRin;
    logic       Yin;
    logic       Zin;
    logic       Zlowout;
    logic       Read;
    logic       RAM_read;
    logic       RAM_write;
    logic       GRA;
    logic       GRB;
    logic       GRC;
    logic       Rin;
    logic       Rout;
    logic       BAout;
    logic       Cout;
    logic       CONin;
    logic [4:0] opcode;
  } strobes_t;

  function automatic logic is_defined(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_BR, OP_JR, OP_NOP, OP_HALT: is_defined = 1'b1;
      default:                       is_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_step_decode.sv
// Combinational strobe decode for one control step: (state, opcode, con_ff) -> strobe vector.
module seq_step_decode
  import seq_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] op,
  input  logic       con_ff,
  output strobes_t   strobes
);

  logic is_alu;
  logic is_imm;
  logic is_mem;

  assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_imm = (op == OP_ADDI) || (op == OP_LDI);
  assign is_mem = (op == OP_LD) || (op == OP_ST);

  always_comb begin
    strobes = '0;
    case (state)
      S_T0: begin
        strobes.PCout = 1'b1;
        strobes.MARin = 1'b1;
        strobes.IncPC = 1'b1;
        strobes.Zin   = 1'b1;
      end
      S_T1: begin
        strobes.Zlowout  = 1'b1;
        strobes.PCin     = 1'b1;
        strobes.Read     = 1'b1;
        strobes.RAM_read = 1'b1;
        strobes.MDRin    = 1'b1;
      end
      S_T2: begin
        strobes.MDRout = 1'b1;
        strobes.IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu || op == OP_ADDI) begin
          strobes.GRB  = 1'b1;
          strobes.Rout = 1'b1;
          strobes.Yin  = 1'b1;
        end else if (op == OP_LDI || is_mem) begin
          strobes.GRB   = 1'b1;
          strobes.BAout = 1'b1;
          strobes.Yin   = 1'b1;
        end else if (op == OP_BR) begin
          strobes.GRA   = 1'b1;
          strobes.Rout  = 1'b1;
          strobes.CONin = 1'b1;
        end else if (op == OP_JR) begin
          strobes.GRA  = 1'b1;
          strobes.Rout = 1'b1;
          strobes.PCin = 1'b1;
        end
      end
      S_T4: begin
        if (is_alu) begin
          strobes.GRC    = 1'b1;
          strobes.Rout   = 1'b1;
          strobes.Zin    = 1'b1;
          strobes.opcode = op;
        end else if (is_imm || is_mem) begin
          strobes.Cout   = 1'b1;
          strobes.Zin    = 1'b1;
          strobes.opcode = ALU_ADD;
        end else if (op == OP_BR) begin
          strobes.PCout = 1'b1;
          strobes.Yin   = 1'b1;
        end
      end
      S_T5: begin
        if (is_alu || is_imm) begin
          strobes.Zlowout = 1'b1;
          strobes.GRA     = 1'b1;
          strobes.Rin     = 1'b1;
        end else if (is_mem) begin
          strobes.Zlowout = 1'b1;
          strobes.MARin   = 1'b1;
        end else if (op == OP_BR) begin
          strobes.Cout   = 1'b1;
          strobes.Zin    = 1'b1;
          strobes.opcode = ALU_ADD;
        end
      end
      S_T6: begin
        if (op == OP_LD) begin
          strobes.Read     = 1'b1;
          strobes.RAM_read = 1'b1;
          strobes.MDRin    = 1'b1;
        end else if (op == OP_ST) begin
          // Register data goes to MDR from the bus, so Read stays low.
          strobes.GRA   = 1'b1;
          strobes.Rout  = 1'b1;
          strobes.MDRin = 1'b1;
        end else if (op == OP_BR && con_ff) begin
          strobes.Zlowout = 1'b1;
          strobes.PCin    = 1'b1;
        end
      end
      S_T7: begin
        if (op == OP_LD) begin
          strobes.MDRout = 1'b1;
          strobes.GRA    = 1'b1;
          strobes.Rin    = 1'b1;
        end else if (op == OP_ST) begin
          strobes.RAM_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T7, one step per clock.
// Optional illegal-opcode trap is enabled by defining SEQ_ILLEGAL_TRAP_EN.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int IR_W = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [IR_W-1:0] ir,
  input  logic            con_ff,
  input  logic            stop,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Read,
  output logic            RAM_read,
  output logic            RAM_write,
  output logic            GRA,
  output logic            GRB,
  output logic            GRC,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            CONin,
  output logic [4:0]      opcode,
  output logic            run
`ifdef SEQ_ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);

  state_t     state, state_next;
  logic       armed;
  logic [4:0] op;
  logic       unused_ir;
  strobes_t   raw, gated;

  assign op        = ir[IR_W-1 -: 5];
  assign unused_ir = ^ir[IR_W-6:0];

  // armed is low in reset and for the cycle after release, so T0 is held one extra
  // clock with its strobes masked and the first real T0 follows the release.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_T0;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

`ifdef SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                               illegal <= 1'b0;
    else if (state == S_T3 && !is_defined(op)) illegal <= 1'b1;
  end
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  always_comb begin
    state_t boundary;
    boundary   = stop ? S_IDLE : S_T0;
    state_next = state;
    case (state)
      S_IDLE: state_next = stop ? S_IDLE : S_T0;
      S_T0:   state_next = armed ? S_T1 : S_T0;
      S_T1:   state_next = S_T2;
      S_T2: begin
        if (op == OP_HALT)                  state_next = S_HALT;
        else if (op == OP_NOP)              state_next = boundary;
        else if (!is_defined(op) && !TRAP)  state_next = boundary;
        else                                state_next = S_T3;
      end
      S_T3: begin
        if (!is_defined(op))                state_next = TRAP ? S_HALT : boundary;
        else if (op == OP_JR)               state_next = boundary;
        else                                state_next = S_T4;
      end
      S_T4:   state_next = S_T5;
      S_T5:   state_next = (op == OP_LD || op == OP_ST || op == OP_BR) ? S_T6 : boundary;
      S_T6:   state_next = (op == OP_LD || op == OP_ST) ? S_T7 : boundary;
      S_T7:   state_next = boundary;
      S_HALT: state_next = S_HALT;
      default: state_next = S_T0;
    endcase
  end

  seq_step_decode u_decode (
    .state   (state),
    .op      (op),
    .con_ff  (con_ff),
    .strobes (raw)
  );

  assign gated     = armed ? raw : '0;
  assign run       = (state != S_IDLE) && (state != S_HALT);

  assign PCout     = gated.PCout;
  assign PCin      = gated.PCin;
  assign IncPC     = gated.IncPC;
  assign MARin     = gated.MARin;
  assign MDRin     = gated.MDRin;
  assign MDRout    = gated.MDRout;
  assign IRin      = gated.IRin;
  assign Yin       = gated.Yin;
  assign Zin       = gated.Zin;
  assign Zlowout   = gated.Zlowout;
  assign Read      = gated.Read;
  assign RAM_read  = gated.RAM_read;
  assign RAM_write = gated.RAM_write;
  assign GRA       = gated.GRA;
  assign GRB       = gated.GRB;
  assign GRC       = gated.GRC;
  assign Rin       = gated.Rin;
  assign Rout      = gated.Rout;
  assign BAout     = gated.BAout;
  assign Cout      = gated.Cout;
  assign CONin     = gated.CONin;
  assign opcode    = gated.opcode;

endmodule
